// File: rtl/clk_meter_pkg.sv
// Purpose: shared state encoding and default constants for the clock period meter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } meter_state_e;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_EXP_10K  = 100;  // 10 kHz measured with a 1 MHz reference
  localparam int DEF_EXP_100K = 10;   // 100 kHz measured with a 1 MHz reference
  localparam int DEF_TOL      = 2;
  localparam int DEF_LOCK_N   = 4;
  localparam int DEF_TIMEOUT  = 400;

endpackage

// File: rtl/sync_edge_det.sv
// Purpose: two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
// Latency: rise_o is high in the cycle after the second sync flop captures the new level.
// Backpressure: none; free-running.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s2_d_q;

  // Metastability filter and one-cycle history for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s2_d_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s2_d_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s2_d_q;

endmodule

// File: rtl/clk_period_meter.sv
// Purpose: measures the period of a slow async input in reference cycles, checks tolerance, tracks lock and loss.
// Latency: period_valid pulses 3 reference cycles after the clk_in rising edge that closes a period.
// Backpressure: none; results are pulses, sticky timeout_err clears only via enable low or reset.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = DEF_EXP_10K,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_N     = DEF_LOCK_N,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clock1M,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             timeout_err
);

  localparam int LW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W:0]   LO_LIM  = (CNT_W+1)'((EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0);
  localparam logic [CNT_W:0]   HI_LIM  = (CNT_W+1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_N);

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             tol_q, tol_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             to_q, to_d;

  logic             rise;
  logic [CNT_W:0]   meas;
  logic             tol_now;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;

  sync_edge_det u_sync (
    .clk_i  (clock1M),
    .rst_ni (reset),
    .d_i    (clk_in),
    .rise_o (rise)
  );

  // Period is cnt+1, computed one bit wider so the tolerance window never wraps.
  assign meas        = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign tol_now     = (meas >= LO_LIM) && (meas <= HI_LIM);
  assign timeout_hit = (cnt_q == TO_LAST) && !rise;
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and datapath updates; enable low wins over everything but reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    tol_d      = tol_q;
    lock_cnt_d = lock_cnt_q;
    to_d       = to_q;
    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      lock_cnt_d = '0;
      tol_d      = 1'b0;
      to_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = WAIT_FIRST;
          cnt_d      = '0;
          lock_cnt_d = '0;
          tol_d      = 1'b0;
          to_d       = 1'b0;
        end
        WAIT_FIRST: begin
          if (rise) begin
            cnt_d   = '0;
            state_d = MEASURE;
          end else if (timeout_hit) begin
            to_d       = 1'b1;
            cnt_d      = '0;
            lock_cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d = (cnt_q == CNT_MAX) ? CNT_MAX : meas[CNT_W-1:0];
            valid_d  = 1'b1;
            tol_d    = tol_now;
            cnt_d    = '0;
            if (!tol_now)                  lock_cnt_d = '0;
            else if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LW'(1);
          end else if (timeout_hit) begin
            to_d       = 1'b1;
            cnt_d      = '0;
            lock_cnt_d = '0;
            state_d    = WAIT_FIRST;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign locked_d = (lock_cnt_d == LOCK_MAX);

  // State register with synchronous active-low reset.
  always_ff @(posedge clock1M) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      tol_q      <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      tol_q      <= tol_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      to_q       <= to_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign in_tol       = tol_q;
  assign locked       = locked_q;
  assign timeout_err  = to_q;

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
module tb_clk_period_meter;

  logic clock1M = 1'b0;
  always #5 clock1M = ~clock1M;

  logic reset, en_s, en_f, clk_s, clk_f;
  logic [15:0] per_s, per_f;
  logic vld_s, tol_s, lck_s, to_s;
  logic vld_f, tol_f, lck_f, to_f;

  clk_period_meter dut_s (
    .clock1M(clock1M), .reset(reset), .clk_in(clk_s), .enable(en_s),
    .period_out(per_s), .period_valid(vld_s), .in_tol(tol_s),
    .locked(lck_s), .timeout_err(to_s)
  );

  clk_period_meter #(.EXP_PERIOD(10)) dut_f (
    .clock1M(clock1M), .reset(reset), .clk_in(clk_f), .enable(en_f),
    .period_out(per_f), .period_valid(vld_f), .in_tol(tol_f),
    .locked(lck_f), .timeout_err(to_f)
  );

  int cyc = 0;
  always @(posedge clock1M) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Scoreboard entry: {expected valid cycle, period, in_tol, locked}
  logic [49:0] q_s[$];
  logic [49:0] q_f[$];
  int last_rise[2];
  bit armed[2];
  int lock_m[2];

  // Called right after a rising edge of the measured input is driven.
  task automatic rise_event(input int sel);
    int p, e;
    bit t, l;
    logic [31:0] ce;
    if (armed[sel]) begin
      p = cyc - last_rise[sel];
      e = sel ? 10 : 100;
      t = (p >= e - 2) && (p <= e + 2);
      if (t) begin
        if (lock_m[sel] < 4) lock_m[sel] = lock_m[sel] + 1;
      end else begin
        lock_m[sel] = 0;
      end
      l  = (lock_m[sel] == 4);
      ce = 32'(cyc + 3);
      if (sel) q_f.push_back({ce, p[15:0], t, l});
      else     q_s.push_back({ce, p[15:0], t, l});
    end
    armed[sel]     = 1'b1;
    last_rise[sel] = cyc;
  endtask

  task automatic run_wave(input int sel, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      @(negedge clock1M);
      if (sel) clk_f = 1'b1; else clk_s = 1'b1;
      rise_event(sel);
      repeat (hi) @(negedge clock1M);
      if (sel) clk_f = 1'b0; else clk_s = 1'b0;
      repeat (lo - 1) @(negedge clock1M);
    end
  endtask

  logic [49:0] e_s, e_f;

  // Slow-instance scoreboard consumer.
  always @(negedge clock1M) begin
    if (vld_s) begin
      n_chk++;
      if (q_s.size() == 0) begin
        $display("FAIL slow_unexpected_valid: got period=%0d at cyc %0d, required no pulse", per_s, cyc);
      end else begin
        e_s = q_s.pop_front();
        if ({32'(cyc), per_s, tol_s, lck_s} !== e_s)
          $display("FAIL slow_period: got cyc=%0d per=%0d tol=%0b lck=%0b, required cyc=%0d per=%0d tol=%0b lck=%0b",
                   cyc, per_s, tol_s, lck_s, e_s[49:18], e_s[17:2], e_s[1], e_s[0]);
        else n_pass++;
      end
    end
  end

  // Fast-instance scoreboard consumer.
  always @(negedge clock1M) begin
    if (vld_f) begin
      n_chk++;
      if (q_f.size() == 0) begin
        $display("FAIL fast_unexpected_valid: got period=%0d at cyc %0d, required no pulse", per_f, cyc);
      end else begin
        e_f = q_f.pop_front();
        if ({32'(cyc), per_f, tol_f, lck_f} !== e_f)
          $display("FAIL fast_period: got cyc=%0d per=%0d tol=%0b lck=%0b, required cyc=%0d per=%0d tol=%0b lck=%0b",
                   cyc, per_f, tol_f, lck_f, e_f[49:18], e_f[17:2], e_f[1], e_f[0]);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; en_s = 1'b0; en_f = 1'b0; clk_s = 1'b0; clk_f = 1'b0;
    repeat (3) @(negedge clock1M);
    n_chk++;
    if ({per_s, vld_s, tol_s, lck_s, to_s} !== 20'h0)
      $display("FAIL reset_slow: got %h, required 0", {per_s, vld_s, tol_s, lck_s, to_s});
    else n_pass++;
    n_chk++;
    if ({per_f, vld_f, tol_f, lck_f, to_f} !== 20'h0)
      $display("FAIL reset_fast: got %h, required 0", {per_f, vld_f, tol_f, lck_f, to_f});
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_100k();
    en_f = 1'b1;
    @(negedge clock1M);
    run_wave(1, 5, 5, 5);
    n_chk++;
    if (lck_f !== 1'b1) $display("FAIL fast_locked: got %0b, required 1", lck_f);
    else n_pass++;
    n_chk++;
    if (to_f !== 1'b0) $display("FAIL fast_timeout: got %0b, required 0", to_f);
    else n_pass++;
    en_f = 1'b0;
  endtask

  task automatic test_10k();
    en_s = 1'b1;
    @(negedge clock1M);
    run_wave(0, 5, 50, 50);
    n_chk++;
    if (lck_s !== 1'b1) $display("FAIL lock_10k: got %0b, required 1", lck_s);
    else n_pass++;
  endtask

  task automatic test_out_of_tol();
    run_wave(0, 1, 55, 50);
    run_wave(0, 5, 50, 50);
    n_chk++;
    if (lck_s !== 1'b1) $display("FAIL relock: got %0b, required 1", lck_s);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int r;
    r = last_rise[0];
    while (cyc < r + 402) @(negedge clock1M);
    n_chk++;
    if ({to_s, lck_s} !== 2'b01) $display("FAIL timeout_early: got to/lck=%b, required 01", {to_s, lck_s});
    else n_pass++;
    @(negedge clock1M);
    n_chk++;
    if ({to_s, lck_s} !== 2'b10) $display("FAIL timeout_edge: got to/lck=%b, required 10", {to_s, lck_s});
    else n_pass++;
    armed[0] = 1'b0; lock_m[0] = 0;
    run_wave(0, 3, 50, 50);
    n_chk++;
    if (to_s !== 1'b1) $display("FAIL timeout_sticky: got %0b, required 1", to_s);
    else n_pass++;
    @(negedge clock1M);
    en_s = 1'b0;
    @(negedge clock1M);
    n_chk++;
    if ({to_s, lck_s, per_s} !== {2'b00, 16'd100})
      $display("FAIL timeout_clear: got to=%0b lck=%0b per=%0d, required 0 0 100", to_s, lck_s, per_s);
    else n_pass++;
    en_s = 1'b1;
    armed[0] = 1'b0; lock_m[0] = 0;
  endtask

  task automatic test_enable_toggle();
    run_wave(0, 5, 50, 50);
    n_chk++;
    if (lck_s !== 1'b1) $display("FAIL en_prelock: got %0b, required 1", lck_s);
    else n_pass++;
    @(negedge clock1M);
    en_s = 1'b0;
    @(negedge clock1M);
    n_chk++;
    if ({lck_s, vld_s, per_s} !== {2'b00, 16'd100})
      $display("FAIL en_drop: got lck=%0b vld=%0b per=%0d, required 0 0 100", lck_s, vld_s, per_s);
    else n_pass++;
    en_s = 1'b1;
    armed[0] = 1'b0; lock_m[0] = 0;
    run_wave(0, 5, 50, 50);
    n_chk++;
    if (lck_s !== 1'b1) $display("FAIL en_relock: got %0b, required 1", lck_s);
    else n_pass++;
  endtask

  task automatic test_edge_wins();
    run_wave(0, 1, 50, 350);
    run_wave(0, 1, 50, 50);
    n_chk++;
    if ({to_s, lck_s, tol_s} !== 3'b000)
      $display("FAIL edge_wins: got to/lck/tol=%b, required 000", {to_s, lck_s, tol_s});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    run_wave(0, 1, 50, 30);
    @(negedge clock1M);
    reset = 1'b0;
    @(negedge clock1M);
    n_chk++;
    if ({per_s, vld_s, tol_s, lck_s, to_s} !== 20'h0)
      $display("FAIL reset_mid: got %h, required 0", {per_s, vld_s, tol_s, lck_s, to_s});
    else n_pass++;
    repeat (2) @(negedge clock1M);
    reset = 1'b1;
    armed[0] = 1'b0; lock_m[0] = 0;
    n_chk++;
    if (q_s.size() != 0) $display("FAIL reset_pending: got %0d queued, required 0", q_s.size());
    else n_pass++;
    run_wave(0, 4, 50, 50);
    n_chk++;
    if ({per_s, tol_s, lck_s} !== {16'd100, 2'b10})
      $display("FAIL reset_remeasure: got per=%0d tol=%0b lck=%0b, required 100 1 0", per_s, tol_s, lck_s);
    else n_pass++;
  endtask

  initial begin
    armed[0] = 1'b0; armed[1] = 1'b0;
    lock_m[0] = 0; lock_m[1] = 0;
    last_rise[0] = 0; last_rise[1] = 0;
    test_reset();
    test_100k();
    test_10k();
    test_out_of_tol();
    test_timeout();
    test_enable_toggle();
    test_edge_wins();
    test_reset_mid();
    repeat (5) @(negedge clock1M);
    n_chk++;
    if (q_s.size() + q_f.size() != 0)
      $display("FAIL missing_valid: got %0d outstanding, required 0", q_s.size() + q_f.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
